// File: rtl/dequantize.sv
// Streaming dequantizer: widens packed signed 8-bit pixels to
// 32-bit accumulator values (pixel * scale, shifted), 2-stage pipe.
module dequantize #(
    parameter int SIZE        = 4,
    parameter int SHIFT       = 3,
    parameter int FRAME_BEATS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           scale_in,
    input  logic                 scale_load,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*SIZE-1:0]    pixel_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*SIZE-1:0]   pixel_out,
    output logic                 out_last
);

    localparam int CW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BEATS - 1);

    logic [7:0]           scale_q;
    logic                 s1_valid_q, s1_valid_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [17*SIZE-1:0]   prod_q, prod_d;
    logic [32*SIZE-1:0]   res_q, res_d;
    logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
    logic                 adv1, adv2, in_xfer, out_xfer;

    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;
    assign in_xfer  = in_valid && adv1;
    assign out_xfer = s2_valid_q && out_ready;

    assign out_valid = s2_valid_q;
    assign pixel_out = res_q;
    assign out_last  = s2_valid_q && (beat_cnt_q == LAST_IDX);

    // Per-lane multiply (stage 1 input) and shift (stage 2 input).
    // Scale is zero-extended so 255 stays positive; 17 bits always suffice.
    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic signed [16:0] px, sc, p;
        logic signed [31:0] pw, r;
        assign px = {{9{pixel_in[8*i+7]}}, pixel_in[8*i +: 8]};
        assign sc = {9'b0, scale_q};
        assign p  = px * sc;
        assign prod_d[17*i +: 17] = p;
        assign pw = {{15{prod_q[17*i+16]}}, prod_q[17*i +: 17]};
        if (SHIFT >= 0) begin : g_left
            assign r = pw <<< SHIFT;
        end else begin : g_right
            assign r = pw >>> (-SHIFT);
        end
        assign res_d[32*i +: 32] = r;
    end

    // Next-state for the valid bits and the output-beat counter.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        beat_cnt_d = beat_cnt_q;
        if (adv1) s1_valid_d = in_valid;
        if (adv2) s2_valid_d = s1_valid_q;
        if (out_xfer)
            beat_cnt_d = (beat_cnt_q == LAST_IDX) ? '0 : beat_cnt_q + 1'b1;
    end

    // Pipeline registers; data only moves on the matching advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            prod_q     <= '0;
            res_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            beat_cnt_q <= beat_cnt_d;
            if (in_xfer) prod_q <= prod_d;
            if (adv2 && s1_valid_q) res_q <= res_d;
        end
    end

    // Scale register; a beat accepted on the load edge used the old value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) scale_q <= 8'd1;
        else if (scale_load) scale_q <= scale_in;
    end

endmodule

// File: tb/tb_dequantize.sv
// Self-checking bench for dequantize: three parameterisations share
// one stimulus stream and are checked against a per-instance model.
module tb_dequantize;

    localparam int NI = 3;

    logic         clock = 1'b0;
    logic         reset;
    logic [7:0]   scale_in;
    logic         scale_load;
    logic         in_valid;
    logic [31:0]  pixel_in;
    logic         out_ready;
    logic         in_ready  [NI];
    logic         out_valid [NI];
    logic [127:0] pixel_out [NI];
    logic         out_last  [NI];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dequantize #(.SIZE(4), .SHIFT(3), .FRAME_BEATS(4)) u_a (
        .clock(clock), .reset(reset), .scale_in(scale_in),
        .scale_load(scale_load), .in_valid(in_valid),
        .in_ready(in_ready[0]), .pixel_in(pixel_in),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .pixel_out(pixel_out[0]), .out_last(out_last[0]));

    dequantize #(.SIZE(4), .SHIFT(-3), .FRAME_BEATS(16)) u_b (
        .clock(clock), .reset(reset), .scale_in(scale_in),
        .scale_load(scale_load), .in_valid(in_valid),
        .in_ready(in_ready[1]), .pixel_in(pixel_in),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .pixel_out(pixel_out[1]), .out_last(out_last[1]));

    dequantize #(.SIZE(4), .SHIFT(15), .FRAME_BEATS(1)) u_c (
        .clock(clock), .reset(reset), .scale_in(scale_in),
        .scale_load(scale_load), .in_valid(in_valid),
        .in_ready(in_ready[2]), .pixel_in(pixel_in),
        .out_valid(out_valid[2]), .out_ready(out_ready),
        .pixel_out(pixel_out[2]), .out_last(out_last[2]));

    function automatic int sh_of(int k);
        case (k)
            0:       return 3;
            1:       return -3;
            default: return 15;
        endcase
    endfunction

    function automatic int fb_of(int k);
        case (k)
            0:       return 4;
            1:       return 16;
            default: return 1;
        endcase
    endfunction

    // Expected beat from plain integer arithmetic.
    function automatic logic [127:0] model_beat(logic [31:0] px, int sc, int sh);
        logic [127:0] r;
        byte b;
        int v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            b = px[8*i +: 8];
            v = b * sc;
            if (sh >= 0) v = v <<< sh;
            else v = v >>> (-sh);
            r[32*i +: 32] = v;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Model state.
    logic [127:0] qd [NI][$];
    int           qt [NI][$];
    int           ocnt [NI];
    int           mscale = 1;
    int           cyc = 0;

    task automatic model_clear();
        for (int k = 0; k < NI; k++) begin
            qd[k].delete();
            qt[k].delete();
            ocnt[k] = 0;
        end
        mscale = 1;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (!reset) begin
            cyc++;
            for (int k = 0; k < NI; k++) begin
                bit ev;
                ev = (qd[k].size() > 0) && (cyc - qt[k][0] >= 2);
                chk($sformatf("in_ready[%0d]", k), 128'(in_ready[k]),
                    128'((qd[k].size() < 2) || out_ready));
                chk($sformatf("out_valid[%0d]", k), 128'(out_valid[k]), 128'(ev));
                if (ev) begin
                    chk($sformatf("pixel_out[%0d]", k), pixel_out[k], qd[k][0]);
                    chk($sformatf("out_last[%0d]", k), 128'(out_last[k]),
                        128'(ocnt[k] == fb_of(k) - 1));
                    if (out_ready) begin
                        void'(qd[k].pop_front());
                        void'(qt[k].pop_front());
                        ocnt[k] = (ocnt[k] + 1) % fb_of(k);
                    end
                end
                if (in_valid && in_ready[k]) begin
                    qd[k].push_back(model_beat(pixel_in, mscale, sh_of(k)));
                    qt[k].push_back(cyc);
                end
            end
            if (scale_load) mscale = scale_in;
        end
    end

    // Frame-position monitor on instance A (FRAME_BEATS=4).
    int           nout = 0;
    logic [31:0]  lastmask = '0;
    logic [127:0] firstdat = '0;
    always @(negedge clock) begin
        if (reset) begin
            nout = 0;
            lastmask = '0;
        end else if (out_valid[0] && out_ready) begin
            nout++;
            if (nout == 1) firstdat = pixel_out[0];
            if (out_last[0]) lastmask[nout] = 1'b1;
        end
    end

    task automatic send(input logic [31:0] px, input bit ld = 0, input logic [7:0] sc = 0);
        int guard;
        in_valid = 1'b1;
        pixel_in = px;
        scale_load = ld;
        scale_in = sc;
        guard = 0;
        @(negedge clock);
        while (!in_ready[0] && guard < 100) begin
            guard++;
            @(negedge clock);
        end
        if (guard >= 100) chk("send_timeout", 128'(guard), 128'(0));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        scale_load = 1'b0;
    endtask

    task automatic load_scale(input logic [7:0] sc);
        scale_in = sc;
        scale_load = 1'b1;
        @(posedge clock);
        #1;
        scale_load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] held;
        bit           seen_low;
        reset = 1'b1;
        scale_in = '0;
        scale_load = 1'b0;
        in_valid = 1'b0;
        pixel_in = '0;
        out_ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset_in_ready", 128'(in_ready[0]), 128'(1));
        chk("reset_out_valid", 128'(out_valid[0]), 128'(0));
        chk("reset_pixel_out", pixel_out[0], 128'(0));
        idle(2);

        // Test 1: SHIFT=3 scale=1, plus SHIFT=15 on instance C.
        send(32'h00ff7f80);
        @(negedge clock);
        chk("t1_latency_s1", 128'(out_valid[0]), 128'(0));
        @(negedge clock);
        chk("t1_valid", 128'(out_valid[0]), 128'(1));
        chk("t1_a", pixel_out[0], 128'h00000000_fffffff8_000003f8_fffffc00);
        chk("t1_c", pixel_out[2], 128'h00000000_ffff8000_003f8000_ffc00000);
        chk("t1_c_last", 128'(out_last[2]), 128'(1));
        idle(2);

        // Test 2: SHIFT=-3 on instance B.
        send(32'h0fab7f80);
        repeat (2) @(negedge clock);
        chk("t2_b", pixel_out[1], 128'h00000001_fffffff5_0000000f_fffffff0);
        idle(2);

        // Test 3: load on the same edge as a beat; next beat sees scale 3.
        send(32'h7f7f7f7f, 1, 8'd3);
        send(32'h7f7f7f7f);
        @(negedge clock);
        chk("t3_old_scale", pixel_out[0], {4{32'h000003f8}});
        @(negedge clock);
        chk("t3_new_scale", pixel_out[0], {4{32'h00000be8}});
        idle(2);

        // Scale 0 gives zero output.
        load_scale(8'd0);
        send(32'h80ff7f01);
        repeat (2) @(negedge clock);
        chk("scale0_valid", 128'(out_valid[0]), 128'(1));
        chk("scale0_zero", pixel_out[0], 128'(0));
        idle(1);
        load_scale(8'd1);
        idle(2);

        // Test 4: five beats with a 3-cycle downstream stall.
        seen_low = 0;
        fork
            begin
                for (int j = 0; j < 5; j++) send(32'h01020304 + 32'(j) * 32'h11111111);
            end
            begin
                repeat (2) @(posedge clock);
                #1;
                out_ready = 1'b0;
                held = '0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clock);
                    if (!in_ready[0]) seen_low = 1;
                    if (j == 0) held = pixel_out[0];
                    else chk("t4_stable", pixel_out[0], held);
                end
                @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        chk("t4_in_ready_low", 128'(seen_low), 128'(1));
        idle(4);

        // Test 6: reset with two beats in flight, scale 3 beforehand.
        load_scale(8'd3);
        send(32'h11223344);
        send(32'h55667788);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("t6_valid[%0d]", k), 128'(out_valid[k]), 128'(0));
            chk($sformatf("t6_data[%0d]", k), pixel_out[k], 128'(0));
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("t6_in_ready", 128'(in_ready[0]), 128'(1));
        idle(1);

        // Test 5: nine back-to-back beats on FRAME_BEATS=4.
        for (int j = 0; j < 9; j++) send(32'h7f7f7f7f);
        idle(4);
        chk("t5_count", 128'(nout), 128'(9));
        chk("t5_lastmask", 128'(lastmask), 128'h110);
        chk("t5_scale_reset", firstdat, {4{32'h000003f8}});

        idle(4);
        for (int k = 0; k < NI; k++)
            chk($sformatf("drain[%0d]", k), 128'(qd[k].size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
